fetch_stage: RTL

//  Instruction fetch stage: owns the PC, issues requests to instruction memory and presents
//  one instruction per slot (f_instr/f_pc/f_stall) to the fetch->decode pipeline register.

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC owner, imem request issue, one-entry skid and redirect kill.
// Optional build macro FETCH_ALIGN_CHECK_EN adds misaligned-redirect trapping (f_misalign).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] EXC_PC   = 32'h0000_2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hazard_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_stall
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        f_misalign
`endif
);

  typedef enum logic [1:0] {REQ, HOLD, KILL} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] kill_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned      = |redirect_pc[1:0];
  assign redirect_target = misaligned ? EXC_PC : redirect_pc;
`else
  logic unused_align_bits;
  assign redirect_target   = {redirect_pc[31:2], 2'b00};
  assign unused_align_bits = ^{redirect_pc[1:0], EXC_PC};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= REQ;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      REQ: begin
        if (redirect)                      next_state = imem_ack ? REQ : KILL;
        else if (imem_ack && hazard_stall) next_state = HOLD;
      end
      HOLD: if (redirect || !hazard_stall) next_state = REQ;
      // a redirect while killing keeps waiting for the stale response
      KILL: if (imem_ack) next_state = REQ;
      default: next_state = REQ;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      REQ:  imem_req = 1'b1;
      KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr;
      end
      default: imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      kill_addr  <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      f_instr    <= 32'h0;
      f_pc       <= 32'h0;
      f_stall    <= 1'b1;
    end else if (redirect) begin
      pc      <= redirect_target;
      f_instr <= 32'h0;
      f_stall <= 1'b1;
      if (state == REQ && !imem_ack) kill_addr <= pc;
`ifdef FETCH_ALIGN_CHECK_EN
      if (misaligned) f_pc <= redirect_pc;
`endif
    end else begin
      case (state)
        REQ: begin
          if (imem_ack) begin
            pc <= pc + 32'd4;
            if (hazard_stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
            end else begin
              f_instr <= imem_rdata;
              f_pc    <= pc;
              f_stall <= 1'b0;
            end
          end else if (!hazard_stall) begin
            f_instr <= 32'h0;
            f_stall <= 1'b1;
          end
        end
        HOLD: begin
          if (!hazard_stall) begin
            f_instr <= skid_instr;
            f_pc    <= skid_pc;
            f_stall <= 1'b0;
          end
        end
        KILL: begin
          if (!hazard_stall) begin
            f_instr <= 32'h0;
            f_stall <= 1'b1;
          end
        end
        default: f_stall <= 1'b1;
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              f_misalign <= 1'b0;
    else if (redirect)      f_misalign <= misaligned;
    else if (!hazard_stall) f_misalign <= 1'b0;
  end
`endif

endmodule
